// File: rtl/csr_write_sequencer_if.sv
// Request channel into the CSR write sequencer: one 4-bit address/data
// write per valid/ready handshake.
interface csr_write_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_addr;
  logic [3:0] req_data;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/csr_write_sequencer.sv
// Drives the PLL tile CSR write port: buffers requests and replays each one
// as a setup / high / hold strobe on csr_clk_out with addr/data held around it.
module csr_write_sequencer #(
  parameter int SETUP_CYC  = 2,
  parameter int HIGH_CYC   = 2,
  parameter int HOLD_CYC   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  csr_write_sequencer_if.slave          req,
  input  logic                          clr_err,
  output logic [3:0]                    csr_addr_out,
  output logic [3:0]                    csr_data_out,
  output logic                          csr_clk_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    wr_count,
  output logic                          unmapped_err
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int MAXC = (SETUP_CYC > HIGH_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((HIGH_CYC  > HOLD_CYC) ? HIGH_CYC  : HOLD_CYC);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} state_t;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] data;
  } wr_req_t;

  state_t         state;
  logic [CW-1:0]  cnt;

  wr_req_t        mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  count;

  logic           accept, mapped, push, pop, drop, fifo_full;

  assign fifo_full     = (count == LW'(FIFO_DEPTH));
  assign req.req_ready = !fifo_full;
  assign accept        = req.req_valid && !fifo_full;
  assign mapped        = (req.req_addr <= 4'hC);
  assign push          = accept && mapped;
  assign drop          = accept && !mapped;
  // Pop only from IDLE, and only what was already registered: no fall-through.
  assign pop           = (state == IDLE) && (count != '0);

  assign fifo_level    = count;
  assign busy          = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: req.req_addr, data: req.req_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A fresh drop outranks a clear arriving on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       unmapped_err <= 1'b0;
    else if (drop)    unmapped_err <= 1'b1;
    else if (clr_err) unmapped_err <= 1'b0;
  end

  // Reset parks the address on 0xF so any edge seen during power-up is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      csr_clk_out  <= 1'b0;
      csr_addr_out <= 4'hF;
      csr_data_out <= 4'h0;
      wr_count     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            csr_addr_out <= mem[rd_ptr].addr;
            csr_data_out <= mem[rd_ptr].data;
            cnt          <= CW'(SETUP_CYC - 1);
            state        <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            csr_clk_out <= 1'b1;
            wr_count    <= wr_count + 8'd1;
            cnt         <= CW'(HIGH_CYC - 1);
            state       <= HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            csr_clk_out <= 1'b0;
            cnt         <= CW'(HOLD_CYC - 1);
            state       <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_write_sequencer.sv
// Randomized bench for csr_write_sequencer: a timeline model predicts every
// write's start cycle from accept times and the fixed write period.
module tb_csr_write_sequencer;
  localparam int S = 2, H = 2, D = 2, P = 1 + S + H + D, DEPTH = 4;

  logic       clk = 1'b0, rst_n = 1'b0, clr_err = 1'b0;
  logic [3:0] csr_addr_out, csr_data_out;
  logic       csr_clk_out, busy, unmapped_err;
  logic [2:0] fifo_level;
  logic [7:0] wr_count;
  logic [3:0] a1, d1;
  logic       c1, b1, e1;
  logic [2:0] l1;
  logic [7:0] w1;

  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  csr_write_sequencer_if rif ();
  csr_write_sequencer_if rif1 ();

  csr_write_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req(rif), .clr_err(clr_err),
    .csr_addr_out(csr_addr_out), .csr_data_out(csr_data_out),
    .csr_clk_out(csr_clk_out), .busy(busy), .fifo_level(fifo_level),
    .wr_count(wr_count), .unmapped_err(unmapped_err)
  );

  csr_write_sequencer #(.SETUP_CYC(1), .HIGH_CYC(1), .HOLD_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(rif1), .clr_err(1'b0),
    .csr_addr_out(a1), .csr_data_out(d1), .csr_clk_out(c1), .busy(b1),
    .fifo_level(l1), .wr_count(w1), .unmapped_err(e1)
  );

  // Reference model: list of accepted writes with the cycle their addr appears.
  int         start_q[$];
  logic [7:0] wd_q[$];
  int         cyc = 0, last_start = -100;
  logic       m_err = 1'b0;
  logic [22:0] exp_vec;

  function automatic int m_level(int t);
    int n = start_q.size();
    foreach (start_q[k]) if (start_q[k] <= t) n--;
    return n;
  endfunction

  function automatic logic [22:0] m_expect(int t);
    int last = -1, wr = 0, lvl, s;
    logic [3:0] a = 4'hF, d = 4'h0;
    logic ck = 1'b0, act = 1'b0;
    foreach (start_q[k]) begin
      if (start_q[k] <= t) last = k;
      if (start_q[k] + S <= t) wr++;
    end
    lvl = start_q.size() - (last + 1);
    if (last >= 0) begin
      s   = start_q[last];
      a   = wd_q[last][7:4];
      d   = wd_q[last][3:0];
      ck  = (t >= s + S) && (t < s + S + H);
      act = (t < s + P - 1);
    end
    return {lvl < DEPTH, lvl[2:0], ck, a, d, act || (lvl != 0), wr[7:0], m_err};
  endfunction

  initial begin
    int st;
    logic acc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        start_q.delete(); wd_q.delete();
        cyc = 0; last_start = -100; m_err = 1'b0;
      end else begin
        acc = rif.req_valid && (m_level(cyc) < DEPTH);
        if (acc && rif.req_addr <= 4'hC) begin
          st = (cyc + 2 > last_start + P) ? cyc + 2 : last_start + P;
          start_q.push_back(st);
          wd_q.push_back({rif.req_addr, rif.req_data});
          last_start = st;
        end
        if (acc && rif.req_addr > 4'hC) m_err = 1'b1;
        else if (clr_err)               m_err = 1'b0;
        cyc++;
      end
      exp_vec = m_expect(cyc);
    end
  end

  // Addr/data must stay frozen while the strobe is high.
  logic       prev_clk = 1'b0;
  logic [7:0] prev_ad = 8'h0;
  int         stab_viol = 0;
  always @(negedge clk) begin
    if (rst_n && csr_clk_out && prev_clk && {csr_addr_out, csr_data_out} !== prev_ad)
      stab_viol <= stab_viol + 1;
    prev_clk <= csr_clk_out;
    prev_ad  <= {csr_addr_out, csr_data_out};
  end

  function automatic logic [22:0] snap();
    return {rif.req_ready, fifo_level, csr_clk_out, csr_addr_out, csr_data_out,
            busy, wr_count, unmapped_err};
  endfunction

  task automatic do_reset();
    rif.req_valid = 1'b0; rif.req_addr = 4'h0; rif.req_data = 4'h0;
    rif1.req_valid = 1'b0; rif1.req_addr = 4'h0; rif1.req_data = 4'h0;
    clr_err = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [22:0] o;
    do_reset();
    o = snap();
    checks++;
    if (o !== {1'b1, 3'd0, 1'b0, 4'hF, 4'h0, 1'b0, 8'd0, 1'b0})
      $display("FAIL reset_state got=%h exp=%h", o, {1'b1, 3'd0, 1'b0, 4'hF, 4'h0, 1'b0, 8'd0, 1'b0});
    else passed++;
  endtask

  task automatic test_single();
    logic [22:0] o;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      o = snap();
      checks++;
      if (o !== exp_vec) $display("FAIL single c=%0d got=%h exp=%h", c, o, exp_vec);
      else passed++;
      if (c == 4) begin
        checks++;
        if ({csr_clk_out, csr_addr_out, csr_data_out} !== {1'b1, 4'h8, 4'h5})
          $display("FAIL single_strobe got=%b/%h/%h exp=1/8/5", csr_clk_out, csr_addr_out, csr_data_out);
        else passed++;
      end
      rif.req_valid = (c == 0); rif.req_addr = 4'h8; rif.req_data = 4'h5;
      @(negedge clk);
    end
    checks++;
    if ({busy, wr_count} !== {1'b0, 8'd1})
      $display("FAIL single_done got busy=%b wr=%0d exp busy=0 wr=1", busy, wr_count);
    else passed++;
  endtask

  task automatic test_burst();
    logic [22:0] o;
    logic [7:0] tbl[5];
    int sent = 0;
    logic saw_nr = 1'b0;
    foreach (tbl[i]) tbl[i] = {4'($urandom_range(0, 12)), 4'($urandom_range(0, 15))};
    do_reset();
    for (int c = 0; c < 50; c++) begin
      o = snap();
      checks++;
      if (o !== exp_vec) $display("FAIL burst c=%0d got=%h exp=%h", c, o, exp_vec);
      else passed++;
      if (!rif.req_ready) saw_nr = 1'b1;
      if (sent < 5) begin
        rif.req_valid = 1'b1; {rif.req_addr, rif.req_data} = tbl[sent];
        if (rif.req_ready) sent++;
      end else rif.req_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({saw_nr, wr_count} !== {1'b1, 8'd5})
      $display("FAIL burst_done got backpressure=%b wr=%0d exp 1/5", saw_nr, wr_count);
    else passed++;
  endtask

  task automatic test_unmapped();
    logic [22:0] o;
    for (int c = 0; c < 12; c++) begin
      o = snap();
      checks++;
      if (o !== exp_vec) $display("FAIL unmapped c=%0d got=%h exp=%h", c, o, exp_vec);
      else passed++;
      if (c == 2 || c == 6 || c == 10) begin
        checks++;
        if ({unmapped_err, wr_count} !== {(c != 10), 8'd5})
          $display("FAIL unmapped_flag c=%0d got err=%b wr=%0d exp err=%b wr=5", c, unmapped_err, wr_count, c != 10);
        else passed++;
      end
      rif.req_valid = (c == 0) || (c == 4);
      rif.req_addr  = (c == 0) ? 4'hE : 4'hF;
      rif.req_data  = 4'h3;
      clr_err       = (c == 4) || (c == 8);
      @(negedge clk);
    end
    clr_err = 1'b0; rif.req_valid = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [22:0] o;
    int sent = 0;
    logic hit = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      o = snap();
      checks++;
      if (o !== exp_vec) $display("FAIL midop c=%0d got=%h exp=%h", c, o, exp_vec);
      else passed++;
      if (csr_clk_out) begin hit = 1'b1; break; end
      rif.req_valid = (sent < 3); rif.req_addr = 4'(sent + 1); rif.req_data = 4'hA;
      if (rif.req_valid && rif.req_ready) sent++;
      @(negedge clk);
    end
    rif.req_valid = 1'b0;
    checks++;
    if ({hit, fifo_level} !== {1'b1, 3'd2})
      $display("FAIL midop_high got hit=%b level=%0d exp 1/2", hit, fifo_level);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({csr_clk_out, csr_addr_out, fifo_level} !== {1'b0, 4'hF, 3'd0})
      $display("FAIL midop_async got clk=%b addr=%h level=%0d exp 0/f/0", csr_clk_out, csr_addr_out, fifo_level);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      o = snap();
      checks++;
      if (o !== exp_vec) $display("FAIL midop_after c=%0d got=%h exp=%h", c, o, exp_vec);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [22:0] o;
    int sent = 0;
    logic done = 1'b0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      o = snap();
      checks++;
      if (o !== exp_vec) $display("FAIL wrap c=%0d got=%h exp=%h", c, o, exp_vec);
      else passed++;
      if (sent == 256 && !busy) begin done = 1'b1; break; end
      if (sent < 256) begin
        rif.req_valid = 1'b1;
        rif.req_addr  = 4'($urandom_range(0, 12));
        rif.req_data  = 4'($urandom_range(0, 15));
        if (rif.req_ready) sent++;
      end else rif.req_valid = 1'b0;
      @(negedge clk);
    end
    rif.req_valid = 1'b0;
    checks++;
    if ({done, wr_count} !== {1'b1, 8'd0})
      $display("FAIL wrap_done got done=%b wr=%0d exp 1/0", done, wr_count);
    else passed++;
  endtask

  task automatic test_random();
    logic [22:0] o;
    do_reset();
    for (int c = 0; c < 340; c++) begin
      o = snap();
      checks++;
      if (o !== exp_vec) $display("FAIL random c=%0d got=%h exp=%h", c, o, exp_vec);
      else passed++;
      rif.req_valid = (c < 300) && ($urandom_range(0, 1) == 1);
      rif.req_addr  = 4'($urandom_range(0, 15));
      rif.req_data  = 4'($urandom_range(0, 15));
      clr_err       = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    clr_err = 1'b0;
  endtask

  task automatic test_short();
    int rises[$];
    logic [3:0] ra[$];
    logic [3:0] ta[3];
    int highs = 0, sent = 0;
    logic pc = 1'b0;
    foreach (ta[i]) ta[i] = 4'($urandom_range(0, 12));
    do_reset();
    for (int c = 0; c < 24; c++) begin
      if (c1) begin
        highs++;
        if (!pc) begin rises.push_back(c); ra.push_back(a1); end
      end
      pc = c1;
      if (sent < 3) begin
        rif1.req_valid = 1'b1; rif1.req_addr = ta[sent]; rif1.req_data = 4'(sent);
        if (rif1.req_ready) sent++;
      end else rif1.req_valid = 1'b0;
      @(negedge clk);
    end
    rif1.req_valid = 1'b0;
    checks++;
    if (rises.size() !== 3) $display("FAIL short_count got=%0d exp=3", rises.size());
    else passed++;
    checks++;
    if (highs !== 3) $display("FAIL short_high got=%0d exp=3", highs);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ((rises.size() > k ? rises[k] : -1) !== 3 + 4 * k)
        $display("FAIL short_rise k=%0d got=%0d exp=%0d", k, rises.size() > k ? rises[k] : -1, 3 + 4 * k);
      else passed++;
      checks++;
      if ((ra.size() > k ? ra[k] : 4'hF) !== ta[k])
        $display("FAIL short_addr k=%0d got=%h exp=%h", k, ra.size() > k ? ra[k] : 4'hF, ta[k]);
      else passed++;
    end
    checks++;
    if (w1 !== 8'd3) $display("FAIL short_wr got=%0d exp=3", w1);
    else passed++;
  endtask

  task automatic test_stability();
    checks++;
    if (stab_viol !== 0) $display("FAIL stability got=%0d changes while high exp=0", stab_viol);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_unmapped();
    test_reset_midop();
    test_wrap();
    test_random();
    test_short();
    test_stability();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
